// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: access sizes, store lane masks, FSM states.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // The memory presents the addressed byte in bits 31:24, so lanes are always top-justified.
  localparam logic [31:0] MASK_B = 32'hFF00_0000;
  localparam logic [31:0] MASK_H = 32'hFFFF_0000;
  localparam logic [31:0] MASK_W = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane.sv
// Purely combinational lane logic: store mask/data and alignment check, load extraction and extension.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_mask,
  output logic [31:0] st_data,
  output logic        st_err,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  always_comb begin
    st_mask = '0;
    st_data = '0;
    st_err  = 1'b0;
    case (st_size)
      SIZE_B: begin
        st_mask = MASK_B;
        st_data = {st_wdata[7:0], 24'h0};
      end
      SIZE_H: begin
        st_mask = MASK_H;
        st_data = {st_wdata[15:0], 16'h0};
        st_err  = st_addr_lo[0];
      end
      SIZE_W: begin
        st_mask = MASK_W;
        st_data = st_wdata;
        st_err  = |st_addr_lo;
      end
      default: st_err = 1'b1;
    endcase
  end

  always_comb begin
    ld_data = '0;
    case (ld_size)
      SIZE_B:  ld_data = {{24{ld_signed & ld_word[31]}}, ld_word[31:24]};
      SIZE_H:  ld_data = {{16{ld_signed & ld_word[31]}}, ld_word[31:16]};
      SIZE_W:  ld_data = ld_word;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store master for a big-endian word-wide memory.
// Accept -> ACCESS -> CAPTURE -> RESP; errors skip straight to RESP with no memory cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int M = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [1:0]     req_size,
  input  logic           req_signed,
  input  logic [M+1:0]   req_addr,
  input  logic [31:0]    req_wdata,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [31:0]    resp_rdata,
  output logic           resp_err,
  output logic [M+1:0]   mem_address,
  output logic [31:0]    mem_mask,
  output logic [31:0]    mem_w,
  input  logic [31:0]    mem_v
);

  lsu_state_t state, state_nxt;

  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_signed;

  logic [31:0] st_mask;
  logic [31:0] st_data;
  logic        st_err;
  logic [31:0] ld_data;

  lsu_lane u_lane (
    .st_size    (req_size),
    .st_addr_lo (req_addr[1:0]),
    .st_wdata   (req_wdata),
    .st_mask    (st_mask),
    .st_data    (st_data),
    .st_err     (st_err),
    .ld_size    (lat_size),
    .ld_signed  (lat_signed),
    .ld_word    (mem_v),
    .ld_data    (ld_data)
  );

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = st_err ? RESP : ACCESS;
      ACCESS:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clearing mem_mask through the async reset is what suppresses a store caught in ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we      <= 1'b0;
      lat_size    <= SIZE_B;
      lat_signed  <= 1'b0;
      mem_address <= '0;
      mem_mask    <= '0;
      mem_w       <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we     <= req_we;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            if (st_err) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_address <= req_addr;
              mem_mask    <= req_we ? st_mask : '0;
              mem_w       <= req_we ? st_data : '0;
            end
          end
        end
        ACCESS: mem_mask <= '0;
        CAPTURE: begin
          resp_rdata <= lat_we ? '0 : ld_data;
          resp_err   <= 1'b0;
        end
        RESP: begin
          if (resp_ready) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: mem_mask <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench with a byte-array big-endian memory model and a response scoreboard.
module tb_load_store_unit;

  localparam int M  = 10;
  localparam int AW = M + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_mask;
  logic [31:0]   mem_w;
  logic [31:0]   mem_v = '0;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb_q [$];
  logic [7:0]  mem [0:(1<<AW)-1];

  load_store_unit #(.M(M)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_address (mem_address),
    .mem_mask    (mem_mask),
    .mem_w       (mem_w),
    .mem_v       (mem_v)
  );

  always #5 clk = ~clk;

  // Memory: masked write at mem_address, then present the post-write word with that byte on top.
  always @(posedge clk) begin
    logic [31:0]   word;
    logic [AW-1:0] a;
    for (int i = 0; i < 4; i++) begin
      a = mem_address + AW'(i);
      mem[a] = (mem[a] & ~mem_mask[31-8*i -: 8]) | (mem_w[31-8*i -: 8] & mem_mask[31-8*i -: 8]);
      word[31-8*i -: 8] = mem[a];
    end
    mem_v <= word;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        check("resp_rdata", resp_rdata, e[32:1]);
        check("resp_err", {31'd0, resp_err}, {31'd0, e[0]});
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [AW-1:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int          lat;
    logic [31:0] exp_mask;
    logic [31:0] exp_w;
    logic        mask_seen;
    logic        stable;
    logic [31:0] r0;
    case (size)
      2'd0:    begin exp_mask = 32'hFF00_0000; exp_w = {wdata[7:0], 24'h0};  end
      2'd1:    begin exp_mask = 32'hFFFF_0000; exp_w = {wdata[15:0], 16'h0}; end
      default: begin exp_mask = 32'hFFFF_FFFF; exp_w = wdata;                end
    endcase
    if (!we) begin exp_mask = '0; exp_w = '0; end
    if (exp_err) exp_mask = '0;

    @(negedge clk);
    lat = 0;
    while (!req_ready && lat < 20) begin @(negedge clk); lat++; end
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    sb_q.push_back({exp_rdata, exp_err});
    if (hold > 0) resp_ready = 1'b0;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mask_at_accept", mem_mask, exp_mask);
    if (!exp_err) begin
      check("mem_w_at_accept", mem_w, exp_w);
      check("mem_addr_at_accept", 32'(mem_address), 32'(addr));
    end
    lat = 1; mask_seen = 1'b0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (mem_mask != 0) mask_seen = 1'b1;
    end
    check("resp_latency", 32'(lat), exp_err ? 32'd1 : 32'd3);
    check("mask_cleared", {31'd0, mask_seen}, 32'd0);
    if (hold > 0) begin
      r0 = resp_rdata; stable = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!resp_valid || resp_rdata !== r0 || resp_err !== exp_err || req_ready) stable = 1'b0;
      end
      check("backpressure_stable", {31'd0, stable}, 32'd1);
      resp_ready = 1'b1;
    end
    lat = 0;
    while (resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("resp_drained", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_mask", mem_mask, 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);

    //     we   size  sgn   addr      wdata          exp_rdata      err  hold
    do_req(1'b1, 2'd2, 1'b0, 12'h008, 32'hDEADBEEF, 32'h0000_0000, 1'b0, 0);
    do_req(1'b0, 2'd2, 1'b0, 12'h008, 32'h0,        32'hDEADBEEF, 1'b0, 0);
    do_req(1'b1, 2'd0, 1'b0, 12'h009, 32'h12345680, 32'h0000_0000, 1'b0, 0);
    do_req(1'b0, 2'd0, 1'b1, 12'h009, 32'h0,        32'hFFFFFF80, 1'b0, 0);
    do_req(1'b0, 2'd0, 1'b0, 12'h009, 32'h0,        32'h00000080, 1'b0, 0);
    do_req(1'b0, 2'd2, 1'b0, 12'h008, 32'h0,        32'hDE80BEEF, 1'b0, 0);
    do_req(1'b1, 2'd1, 1'b0, 12'h00A, 32'hFFFF1234, 32'h0000_0000, 1'b0, 0);
    do_req(1'b0, 2'd1, 1'b1, 12'h00A, 32'h0,        32'h00001234, 1'b0, 0);
    do_req(1'b0, 2'd2, 1'b0, 12'h008, 32'h0,        32'hDE801234, 1'b0, 0);
    do_req(1'b0, 2'd1, 1'b1, 12'h008, 32'h0,        32'hFFFFDE80, 1'b0, 0);
    do_req(1'b0, 2'd1, 1'b0, 12'h008, 32'h0,        32'h0000DE80, 1'b0, 0);
    do_req(1'b0, 2'd1, 1'b1, 12'h003, 32'h0,        32'h0000_0000, 1'b1, 0);
    do_req(1'b1, 2'd2, 1'b0, 12'h006, 32'hFFFFFFFF, 32'h0000_0000, 1'b1, 0);
    do_req(1'b0, 2'd3, 1'b0, 12'h004, 32'h0,        32'h0000_0000, 1'b1, 0);
    do_req(1'b0, 2'd2, 1'b0, 12'h004, 32'h0,        32'h0000_0000, 1'b0, 0);
    check("mem_6_untouched", {24'd0, mem[12'h006]}, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 12'h008, 32'h0,        32'hDE801234, 1'b0, 5);

    // Byte store interrupted by reset while in ACCESS: no response, no write.
    do_req(1'b1, 2'd2, 1'b0, 12'h020, 32'h11223344, 32'h0000_0000, 1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 12'h021; req_wdata = 32'h000000AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_mask_in_access", mem_mask, 32'hFF00_0000);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mask_async_clear", mem_mask, 32'd0);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("abort_byte_kept", {24'd0, mem[12'h021]}, 32'h22);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 12'h020, 32'h0,        32'h11223344, 1'b0, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits directly upstream of the word-wide, byte-addressed, big-endian synchronous data memory and is its only master. Accepts one CPU load/store request at a time: byte, halfword or word, signed or unsigned loads. Generates the memory address, byte-lane write mask and lane-aligned write data. Extracts and extends the loaded value, returning it through a valid/ready response handshake.

Parameters:
M, 10, log2 of memory depth in words; byte address width is 2+M.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  2+M  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned or illegal-size request
mem_address  out  2+M  memory byte address
mem_mask  out  32  memory write mask (1 = overwrite bit)
mem_w  out  32  memory write data
mem_v  in  32  memory read word, updated every clk edge; byte at mem_address is bits 31:24

Behaviour:
- Memory contract: on every posedge the memory applies mem_mask/mem_w at mem_address, then updates mem_v with the post-write word at mem_address. mem_mask must be 0 whenever no store is intended.
- mem_address, mem_mask and mem_w are registers.
- Reset values: state IDLE; req_ready=1 (combinational from IDLE); resp_valid=0; resp_rdata=0; resp_err=0; mem_address=0; mem_mask=0; mem_w=0.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: req_ready=1. Accept on req_valid at the edge; the request is latched.
  - Illegal size (3), halfword with addr[0]=1, or word with addr[1:0]!=0: go to RESP with resp_err=1 and resp_rdata=0. No memory cycle; mem_mask stays 0.
  - Otherwise load mem_address=req_addr and go to ACCESS.
  - Store byte: mem_mask=FF000000, mem_w={wdata[7:0],24'h0}.
  - Store halfword: mem_mask=FFFF0000, mem_w={wdata[15:0],16'h0}.
  - Store word: mem_mask=FFFFFFFF, mem_w=wdata.
  - Loads: mem_mask=0, mem_w=0.
- ACCESS: one cycle. The memory performs the operation at the closing edge; at that same edge mem_mask clears to 0, mem_address is held, and the FSM goes to CAPTURE.
- CAPTURE: mem_v is valid. Register resp_rdata and go to RESP; resp_err=0.
  - Load byte: resp_rdata = extend(mem_v[31:24]).
  - Load halfword: resp_rdata = extend(mem_v[31:16]).
  - Load word: resp_rdata = mem_v.
  - Stores: resp_rdata=0.
- RESP: resp_valid=1. resp_rdata and resp_err are stable until resp_valid&&resp_ready, then the FSM returns to IDLE and resp_valid=0. req_ready=0 outside IDLE, so no request is accepted in the same cycle as a response handshake.
- Latency: resp_valid rises 3 edges after acceptance (1 edge for errors). Minimum request spacing is 4 cycles with resp_ready held high.
- Reset mid-operation: mem_mask clears asynchronously. A store still in ACCESS when rst_n falls is suppressed; a pending response is discarded.
- Address top: aligned accesses never exceed the last word, so no wrap-around handling is needed.

Decomposition:
- Package lsu_pkg: size constants SIZE_B=0, SIZE_H=1, SIZE_W=2; FSM state enum; mask constants MASK_B/MASK_H/MASK_W.
- One combinational sub-module, lsu_lane:
  - Store direction: size + wdata -> mask + lane data, plus misalign/illegal flag.
  - Load direction: size + signed + mem_v -> extended rdata.
- load_store_unit holds the FSM and all registers.

Test Plan:
- Reset: after rst_n deassert -> req_ready=1, resp_valid=0, mem_mask=0, mem_address=0.
- Store word 0xDEADBEEF at addr 0x8, then load word from 0x8 -> mem_mask=FFFFFFFF only during ACCESS; load returns 0xDEADBEEF, resp_valid 3 cycles after accept.
- Store byte 0x80 at 0x9, then load byte at 0x9 signed -> 0xFFFFFF80; unsigned -> 0x00000080. Load word at 0x8 -> 0xDE80BEEF.
- Store halfword 0x1234 at 0xA, then load halfword at 0xA signed -> 0x00001234. Load word at 0x8 -> 0xDE801234.
- Misaligned halfword load at 0x3, word store at 0x6, size=3 -> resp_err=1, resp_rdata=0 one edge after accept, mem_mask never nonzero, memory contents unchanged.
- Backpressure/reset: hold resp_ready=0 for 5 cycles -> resp_valid and data stable, req_ready=0. Separately, assert rst_n low during ACCESS of a byte store -> target byte unchanged on reload.
